// File: rtl/tse_ssram_pkg.sv
// Shared types and constants for the TSE SSRAM pipelined controller.
// Optional statistics counters are enabled by TSE_SSRAM_CTRL_STATS_EN.
package tse_ssram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RD2WR,
        WR2RD
    } state_t;

    localparam int unsigned READ_LATENCY_DFLT = 2;
    localparam int unsigned TURN_IDLE = 1;

    // Acceptance-to-readdatavalid distance: issue register, SSRAM, capture.
    function automatic int unsigned lat_of(input int unsigned rl);
        return rl + 2;
    endfunction

    localparam int unsigned LAT = lat_of(READ_LATENCY_DFLT);

endpackage

// File: rtl/tse_ssram_rd_pipe.sv
// Read-return tracker: valid shift register plus SSRAM data capture.
// Built the same with or without TSE_SSRAM_CTRL_STATS_EN.
module tse_ssram_rd_pipe
    import tse_ssram_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = LAT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_dq,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid,
    output logic              o_nonempty,
    output logic              o_busy_nxt
);

    logic [DEPTH-1:0]  r_v;
    logic [DEPTH-1:0]  w_v_nxt;
    logic [DATA_W-1:0] r_rdata;

    assign w_v_nxt = {r_v[DEPTH-2:0], i_push};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_v     <= '0;
            r_rdata <= '0;
        end else begin
            r_v <= w_v_nxt;
            // SSRAM data is on the bus in the stage before the return.
            if (r_v[DEPTH-2]) r_rdata <= i_dq;
        end
    end

    assign o_rdata    = r_rdata;
    assign o_rvalid   = r_v[DEPTH-1];
    assign o_nonempty = |r_v;
    assign o_busy_nxt = |w_v_nxt[DEPTH-2:0];

endmodule

// File: rtl/tse_ssram_pipeline_ctrl.sv
// Avalon-MM slave driving a pipelined sync-burst SSRAM, single-beat.
// Define TSE_SSRAM_CTRL_STATS_EN to build the read/write counters.
module tse_ssram_pipeline_ctrl
    import tse_ssram_pkg::*;
#(
    parameter int unsigned ADDR_W       = 21,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = READ_LATENCY_DFLT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic [DATA_W/8-1:0]   avs_byteenable,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [DATA_W-1:0]     avs_writedata,
    output logic                  avs_waitrequest,
    output logic [DATA_W-1:0]     avs_readdata,
    output logic                  avs_readdatavalid,
    output logic [ADDR_W-1:0]     sram_addr,
    input  logic [DATA_W-1:0]     sram_dq_in,
    output logic [DATA_W-1:0]     sram_dq_out,
    output logic                  sram_dq_oe,
    output logic                  sram_adsc_n,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [DATA_W/8-1:0]   sram_be_n,
    output logic [31:0]           stat_rd_cnt,
    output logic [31:0]           stat_wr_cnt
);

    localparam int unsigned BE_W = DATA_W / 8;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_turn, w_turn_nxt;
    logic              w_is_wr, w_is_rd, w_req, w_wait;
    logic              w_acc, w_acc_rd, w_acc_wr;
    logic              w_nonempty, w_busy_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dq_out;
    logic [BE_W-1:0]   r_be_n;
    logic              r_adsc_n, r_ce_n, r_we_n, r_oe_n, r_dq_oe;

    // A simultaneous read and write is treated as a write.
    assign w_is_wr = avs_write;
    assign w_is_rd = avs_read & ~avs_write;
    assign w_req   = avs_read | avs_write;

    always_comb begin
        w_wait      = 1'b1;
        w_state_nxt = r_state;
        w_turn_nxt  = '0;
        unique case (r_state)
            IDLE: begin
                w_wait = 1'b0;
                if (w_is_wr)      w_state_nxt = WR;
                else if (w_is_rd) w_state_nxt = RD;
            end
            RD: begin
                w_wait = w_is_wr;
                if (w_is_wr) w_state_nxt = RD2WR;
            end
            WR: begin
                w_wait = w_is_rd;
                if (w_is_rd) w_state_nxt = WR2RD;
            end
            RD2WR: begin
                if (!w_nonempty) begin
                    if (r_turn >= 2'(TURN_IDLE - 1)) w_state_nxt = IDLE;
                    else w_turn_nxt = r_turn + 2'd1;
                end
            end
            WR2RD:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign avs_waitrequest = ~reset_n | w_wait;
    assign w_acc    = w_req & ~avs_waitrequest;
    assign w_acc_rd = w_acc & w_is_rd;
    assign w_acc_wr = w_acc & w_is_wr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_turn  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_turn  <= w_turn_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_adsc_n <= 1'b1;
            r_ce_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_dq_oe  <= 1'b0;
            r_be_n   <= '1;
            r_addr   <= '0;
            r_dq_out <= '0;
        end else begin
            r_adsc_n <= ~w_acc;
            r_ce_n   <= ~w_acc;
            r_we_n   <= ~w_acc_wr;
            r_dq_oe  <= w_acc_wr;
            r_oe_n   <= ~w_busy_nxt;
            r_be_n   <= w_acc_wr ? ~avs_byteenable : '1;
            if (w_acc)    r_addr   <= avs_address;
            if (w_acc_wr) r_dq_out <= avs_writedata;
        end
    end

    tse_ssram_rd_pipe #(
        .DATA_W (DATA_W),
        .DEPTH  (lat_of(READ_LATENCY))
    ) u_rd_pipe (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_push     (w_acc_rd),
        .i_dq       (sram_dq_in),
        .o_rdata    (avs_readdata),
        .o_rvalid   (avs_readdatavalid),
        .o_nonempty (w_nonempty),
        .o_busy_nxt (w_busy_nxt)
    );

    assign sram_addr   = r_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_adsc_n = r_adsc_n;
    assign sram_ce_n   = r_ce_n;
    assign sram_oe_n   = r_oe_n;
    assign sram_we_n   = r_we_n;
    assign sram_be_n   = r_be_n;

`ifdef TSE_SSRAM_CTRL_STATS_EN
    logic [31:0] r_rd_cnt, r_wr_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_acc_rd && r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 32'd1;
            if (w_acc_wr && r_wr_cnt != '1) r_wr_cnt <= r_wr_cnt + 32'd1;
        end
    end

    assign stat_rd_cnt = r_rd_cnt;
    assign stat_wr_cnt = r_wr_cnt;
`else
    assign stat_rd_cnt = '0;
    assign stat_wr_cnt = '0;
`endif

    a_rw_excl: assert property (@(posedge clk) disable iff (!reset_n)
        !(avs_read && avs_write));

endmodule

// File: tb/tb_tse_ssram_pipeline_ctrl.sv
// Randomised bench for tse_ssram_pipeline_ctrl against a word-level model.
// Expected stats depend on TSE_SSRAM_CTRL_STATS_EN.
module tb_tse_ssram_pipeline_ctrl;

    localparam int LATC = 4;

    logic        clk;
    logic        reset_n;
    logic [20:0] avs_address;
    logic [3:0]  avs_byteenable;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [20:0] sram_addr;
    logic [31:0] sram_dq_in;
    logic [31:0] sram_dq_out;
    logic        sram_dq_oe;
    logic        sram_adsc_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;
    logic [31:0] stat_rd_cnt;
    logic [31:0] stat_wr_cnt;

    tse_ssram_pipeline_ctrl dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avs_address       (avs_address),
        .avs_byteenable    (avs_byteenable),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .sram_addr         (sram_addr),
        .sram_dq_in        (sram_dq_in),
        .sram_dq_out       (sram_dq_out),
        .sram_dq_oe        (sram_dq_oe),
        .sram_adsc_n       (sram_adsc_n),
        .sram_ce_n         (sram_ce_n),
        .sram_oe_n         (sram_oe_n),
        .sram_we_n         (sram_we_n),
        .sram_be_n         (sram_be_n),
        .stat_rd_cnt       (stat_rd_cnt),
        .stat_wr_cnt       (stat_wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    int unsigned n_rd = 0;
    int unsigned n_wr = 0;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] ref_mem [int unsigned];
    logic [31:0] sm_mem  [int unsigned];

    function automatic logic [31:0] init_word(input logic [20:0] a);
        return {11'h0, a} * 32'h9E37_79B1 + 32'h1357_2468;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [20:0] a);
        int unsigned k;
        k = {11'h0, a};
        return ref_mem.exists(k) ? ref_mem[k] : init_word(a);
    endfunction

    function automatic logic [31:0] exp_stat(input int unsigned n);
`ifdef TSE_SSRAM_CTRL_STATS_EN
        return n;
`else
        return (n == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Pin-level SSRAM: address sampled on ADSC, data on dq_in 2 clocks on.
    logic [31:0] m_d1;
    always @(posedge clk) begin
        int unsigned k;
        logic [31:0] w;
        k = {11'h0, sram_addr};
        w = sm_mem.exists(k) ? sm_mem[k] : init_word(sram_addr);
        if (!sram_adsc_n && !sram_ce_n && !sram_we_n && sram_dq_oe)
            sm_mem[k] = merge(w, sram_dq_out, ~sram_be_n);
        if (!sram_adsc_n && !sram_ce_n && sram_we_n) m_d1 <= w;
        else m_d1 <= $urandom;
        sram_dq_in <= m_d1;
    end

    // Return monitor: order, data and exact cycle of every read.
    always @(negedge clk) begin
        if (reset_n) begin
            if (avs_readdatavalid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_rdv cyc=%0d data=%h", cyc,
                             avs_readdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (cyc !== e.due || avs_readdata !== e.data) begin
                        errors++;
                        $display("FAIL rd_return cyc=%0d data=%h want cyc=%0d data=%h",
                                 cyc, avs_readdata, e.due, e.data);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL rd_missing cyc=%0d want cyc=%0d data=%h",
                         cyc, e.due, e.data);
            end
            checks++;
            if (sram_dq_oe && !sram_oe_n) begin
                errors++;
                $display("FAIL bus_contention cyc=%0d dq_oe=1 oe_n=0", cyc);
            end
        end
    end

    task automatic idle();
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic do_req(input bit rd, input bit wr,
                          input logic [20:0] a, input logic [3:0] be,
                          input logic [31:0] wd,
                          output int waits, output int unsigned acc);
        avs_read       = rd;
        avs_write      = wr;
        avs_address    = a;
        avs_byteenable = be;
        avs_writedata  = wd;
        waits = 0;
        acc   = 0;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (!avs_waitrequest) begin
                acc = cyc;
                if (wr) begin
                    ref_mem[{11'h0, a}] = merge(ref_rd(a), wd, be);
                    n_wr++;
                end else begin
                    exp_q.push_back('{due: cyc + LATC, data: ref_rd(a)});
                    n_rd++;
                end
                @(negedge clk);
                return;
            end
            waits++;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL req_timeout addr=%h waits=%0d want accept", a, waits);
        idle();
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout left=%0d want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        avs_read = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (avs_waitrequest !== 1'b1 || avs_readdatavalid !== 1'b0 ||
                avs_readdata !== 32'h0 || sram_adsc_n !== 1'b1 ||
                sram_ce_n !== 1'b1 || sram_oe_n !== 1'b1 ||
                sram_we_n !== 1'b1 || sram_be_n !== 4'hF ||
                sram_dq_oe !== 1'b0 || sram_addr !== 21'h0 ||
                sram_dq_out !== 32'h0 || stat_rd_cnt !== 32'h0 ||
                stat_wr_cnt !== 32'h0) begin
                errors++;
                $display("FAIL reset_state wr=%b rdv=%b adsc=%b ce=%b oe=%b we=%b be=%h dqoe=%b want 1 0 1 1 1 1 f 0",
                         avs_waitrequest, avs_readdatavalid, sram_adsc_n,
                         sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
                         sram_dq_oe);
            end
        end
        idle();
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int w;
        int unsigned acc;
        ref_mem[32'h1234] = 32'hDEAD_BEEF;
        sm_mem[32'h1234]  = 32'hDEAD_BEEF;
        do_req(1'b1, 1'b0, 21'h1234, 4'hF, 32'h0, w, acc);
        idle();
        checks++;
        if (w !== 0 || sram_adsc_n !== 1'b0 || sram_ce_n !== 1'b0 ||
            sram_we_n !== 1'b1 || sram_addr !== 21'h1234) begin
            errors++;
            $display("FAIL single_issue waits=%0d adsc=%b ce=%b we=%b addr=%h want 0 0 0 1 1234",
                     w, sram_adsc_n, sram_ce_n, sram_we_n, sram_addr);
        end
        @(negedge clk);
        checks++;
        if (sram_adsc_n !== 1'b1 || sram_ce_n !== 1'b1) begin
            errors++;
            $display("FAIL single_idle adsc=%b ce=%b want 1 1",
                     sram_adsc_n, sram_ce_n);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int w;
        int tot;
        int unsigned acc;
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            do_req(1'b1, 1'b0, 21'h10 + 21'(i), 4'hF, 32'h0, w, acc);
            tot += w;
        end
        idle();
        checks++;
        if (tot !== 0) begin
            errors++;
            $display("FAIL burst_waits got=%0d want 0", tot);
        end
        drain();
    endtask

    task automatic test_partial_write();
        int w;
        int unsigned acc;
        do_req(1'b0, 1'b1, 21'h20, 4'b0101, 32'hA5A5_A5A5, w, acc);
        idle();
        checks++;
        if (sram_be_n !== 4'b1010 || sram_we_n !== 1'b0 ||
            sram_dq_oe !== 1'b1 || sram_dq_out !== 32'hA5A5_A5A5 ||
            sram_addr !== 21'h20 || sram_adsc_n !== 1'b0) begin
            errors++;
            $display("FAIL pwrite_issue be_n=%b we=%b oe=%b dq=%h addr=%h want 1010 0 1 a5a5a5a5 20",
                     sram_be_n, sram_we_n, sram_dq_oe, sram_dq_out, sram_addr);
        end
        @(negedge clk);
        checks++;
        if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
            errors++;
            $display("FAIL pwrite_release we=%b oe=%b want 1 0",
                     sram_we_n, sram_dq_oe);
        end
        do_req(1'b1, 1'b0, 21'h20, 4'hF, 32'h0, w, acc);
        idle();
        drain();
    endtask

    task automatic test_turnaround();
        int w;
        int unsigned acc;
        do_req(1'b1, 1'b0, 21'h30, 4'hF, 32'h0, w, acc);
        do_req(1'b1, 1'b0, 21'h31, 4'hF, 32'h0, w, acc);
        do_req(1'b0, 1'b1, 21'h32, 4'hC, 32'h1122_3344, w, acc);
        checks++;
        if (w !== LATC + 1) begin
            errors++;
            $display("FAIL rd2wr_waits got=%0d want %0d", w, LATC + 1);
        end
        do_req(1'b1, 1'b0, 21'h32, 4'hF, 32'h0, w, acc);
        idle();
        checks++;
        if (w !== 2) begin
            errors++;
            $display("FAIL wr2rd_waits got=%0d want 2", w);
        end
        drain();
    endtask

    task automatic test_random();
        int w;
        int unsigned acc;
        int unsigned op;
        logic [20:0] a;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 3);
            a  = 21'h40 + 21'($urandom_range(0, 7));
            if (op <= 1)
                do_req(1'b1, 1'b0, a, 4'hF, 32'h0, w, acc);
            else if (op == 2)
                do_req(1'b0, 1'b1, a, 4'($urandom_range(1, 15)),
                       $urandom, w, acc);
            else begin
                idle();
                @(negedge clk);
            end
        end
        idle();
        drain();
        checks++;
        if (stat_rd_cnt !== exp_stat(n_rd) ||
            stat_wr_cnt !== exp_stat(n_wr)) begin
            errors++;
            $display("FAIL stats_random rd=%0d wr=%0d want %0d %0d",
                     stat_rd_cnt, stat_wr_cnt, exp_stat(n_rd), exp_stat(n_wr));
        end
    endtask

    task automatic test_mid_reset();
        int w;
        int unsigned acc;
        do_req(1'b1, 1'b0, 21'h55, 4'hF, 32'h0, w, acc);
        idle();
        @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        n_rd = 0;
        n_wr = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (stat_rd_cnt !== 32'h0 || stat_wr_cnt !== 32'h0) begin
            errors++;
            $display("FAIL stats_after_reset rd=%0d wr=%0d want 0 0",
                     stat_rd_cnt, stat_wr_cnt);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (avs_readdatavalid !== 1'b0 || sram_oe_n !== 1'b1) begin
                errors++;
                $display("FAIL late_rdv rdv=%b oe_n=%b want 0 1",
                         avs_readdatavalid, sram_oe_n);
            end
        end
        do_req(1'b1, 1'b0, 21'h60, 4'hF, 32'h0, w, acc);
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL idle_after_reset waits=%0d want 0", w);
        end
        do_req(1'b1, 1'b0, 21'h61, 4'hF, 32'h0, w, acc);
        do_req(1'b1, 1'b0, 21'h62, 4'hF, 32'h0, w, acc);
        do_req(1'b0, 1'b1, 21'h63, 4'hF, 32'hCAFE_F00D, w, acc);
        do_req(1'b0, 1'b1, 21'h64, 4'h3, 32'h0BAD_BEEF, w, acc);
        idle();
        drain();
        checks++;
        if (stat_rd_cnt !== exp_stat(3) || stat_wr_cnt !== exp_stat(2)) begin
            errors++;
            $display("FAIL stats_3r2w rd=%0d wr=%0d want %0d %0d",
                     stat_rd_cnt, stat_wr_cnt, exp_stat(3), exp_stat(2));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d want finish", cyc);
        $fatal(1);
    end

    initial begin
        reset_n        = 1'b0;
        avs_address    = '0;
        avs_byteenable = '0;
        avs_writedata  = '0;
        avs_write      = 1'b0;
        avs_read       = 1'b0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_partial_write();
        test_turnaround();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tse_ssram_pipeline_ctrl.md
Name: tse_ssram_pipeline_ctrl

Overview:
- Single-clock Avalon-MM slave that sits directly downstream of the TSE SSRAM clock bridge master port, in the master_clk domain.
- Converts bridge reads and writes into pipelined synchronous-burst SSRAM cycles: ADSC-started, single-beat, with byte enables.
- Tracks read latency and returns data with readdatavalid; inserts bus-turnaround cycles between read and write.
- Does no readdata backpressure; the bridge throttles on its own upstream FIFO level.

Parameters:
- ADDR_W, 21, SSRAM word-address width (2M x 32).
- DATA_W, 32, data width; byte lanes = DATA_W/8.
- READ_LATENCY, 2, SSRAM clock edges from address sample to data out (pipelined part).

Ports:
- clk  in  1  master clock.
- reset_n  in  1  synchronous active-low reset.
- avs_address  in  ADDR_W  word address (bridge nativeaddress).
- avs_byteenable  in  DATA_W/8  byte lanes.
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_writedata  in  DATA_W  write data.
- avs_waitrequest  out  1  request not accepted this cycle.
- avs_readdata  out  DATA_W  read data.
- avs_readdatavalid  out  1  avs_readdata valid.
- sram_addr  out  ADDR_W  SSRAM address.
- sram_dq_in  in  DATA_W  SSRAM data bus input.
- sram_dq_out  out  DATA_W  SSRAM data bus output.
- sram_dq_oe  out  1  drive enable for the data bus.
- sram_adsc_n  out  1  address strobe.
- sram_ce_n  out  1  chip enable.
- sram_oe_n  out  1  output enable.
- sram_we_n  out  1  write enable.
- sram_be_n  out  DATA_W/8  byte write enables.
- stat_rd_cnt  out  32  reads accepted.
- stat_wr_cnt  out  32  writes accepted.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on reset_n.
- Reset values, held while reset_n=0:
  - avs_waitrequest=1, avs_readdatavalid=0, avs_readdata=0.
  - sram_adsc_n=1, sram_ce_n=1, sram_oe_n=1, sram_we_n=1.
  - sram_be_n=all 1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
  - Read pipeline cleared. Counters = 0.
- Acceptance: a request is accepted on a cycle where (avs_read|avs_write)=1 and avs_waitrequest=0. avs_waitrequest is combinational from state, pending reads and the request. The master holds the request stable while waited.
- Read and write both asserted (protocol error): write wins, read ignored (simulation assertion).
- Issue: all SSRAM outputs are registered. A request accepted at cycle N drives the SSRAM at N+1 with:
  - sram_adsc_n=0, sram_ce_n=0, sram_addr=address.
  - Write: sram_we_n=0, sram_be_n=~byteenable, sram_dq_oe=1, sram_dq_out=writedata.
- Idle: when no request is issued, adsc_n, ce_n and we_n are 1 and dq_oe=0.
- Read return:
  - sram_dq_in is captured into avs_readdata at N+1+READ_LATENCY+1.
  - avs_readdatavalid=1 for exactly one cycle at LAT = READ_LATENCY+2 cycles after acceptance; default 4.
  - One read accepted per cycle, back-to-back, fully pipelined; returns keep issue order.
- sram_oe_n=0 whenever any read is in flight in the SSRAM stages, else 1.
- States:
  - IDLE: accepts read → RD; accepts write → WR.
  - RD: accepts reads; on a write → RD2WR.
  - RD2WR: waitrequest=1 until the read pipeline is empty, plus one bus-idle cycle → IDLE.
  - WR: accepts writes; on a read → WR2RD.
  - WR2RD: waitrequest=1 for one cycle (dq_oe released) → IDLE.
- Reset mid-operation: in-flight reads are dropped, no late readdatavalid, state → IDLE.
- Counters: +1 per accepted read/write, saturating at 32'hFFFF_FFFF.

Optional Feature:
- Macro TSE_SSRAM_CTRL_STATS_EN.
  - Defined: stat_rd_cnt and stat_wr_cnt count as described above.
  - Undefined: counter logic is removed; both ports are tied to 0.

Decomposition:
- Package tse_ssram_pkg: state enum (IDLE, RD, WR, RD2WR, WR2RD), localparam LAT = READ_LATENCY+2, and the turnaround idle-cycle constant (1).
- One sub-module tse_ssram_rd_pipe: a LAT-deep valid shift register plus the dq_in capture register. It exposes in-flight-nonempty and SSRAM-stage-busy flags used for sram_oe_n and the RD2WR exit.

Test Plan:
- Reset check: hold reset_n=0 for 3 clocks with avs_read=1 → waitrequest=1, no strobes, readdatavalid=0 throughout.
- Single read: read at addr 0x1234 with SSRAM model returning 0xDEADBEEF → sram_adsc_n=0 with addr 0x1234 one cycle later; readdatavalid with 0xDEADBEEF exactly 4 cycles after acceptance.
- Read burst: 8 back-to-back reads at 0x10..0x17 → zero waitrequest cycles, 8 consecutive valid cycles with data in address order.
- Partial write: write 0xA5A5A5A5 to 0x20 with byteenable=4'b0101 → sram_be_n=4'b1010, we_n=0, dq_oe=1 for one cycle; a read-back of 0x20 returns only the written lanes changed.
- Read→write turnaround: 2 reads then a write → write waited until the pipeline drains plus 1 idle cycle; dq_oe never 1 while oe_n=0.
- Mid-read reset: pulse reset_n low 2 cycles after a read is accepted → no readdatavalid afterwards, state IDLE; with TSE_SSRAM_CTRL_STATS_EN defined, counters read 0, and 3 reads plus 2 writes after reset give stat_rd_cnt=3, stat_wr_cnt=2.
